// File: rtl/matrix_accumulate_pkg.sv
`default_nettype none
// ==== matrix_accumulate_pkg : shared types and sizes for the accumulate lane (rev 1.0) ====
package matrix_accumulate_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int LEN_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    ACCUM  = 2'd2,
    RESULT = 2'd3
  } mac_state_t;

endpackage
`default_nettype wire

// File: rtl/matrix_accumulate_controller.sv
`default_nettype none
// ==== matrix_accumulate_controller : clear / stream / capture sequencer for one lane (rev 1.0) ====
module matrix_accumulate_controller #(
  parameter int DATA_WIDTH = matrix_accumulate_pkg::DATA_WIDTH,
  parameter int LEN_WIDTH  = matrix_accumulate_pkg::LEN_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  err_start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  acc_clear,
  output logic                  acc_enable,
  output logic [DATA_WIDTH-1:0] acc_result,
  input  logic [DATA_WIDTH-1:0] acc_out,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data
);
  import matrix_accumulate_pkg::*;

  mac_state_t            r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err_start;
  logic                  r_in_ready;
  logic                  r_acc_clear;
  logic                  r_res_valid;
  logic [DATA_WIDTH-1:0] r_res_data;
  logic [LEN_WIDTH-1:0]  r_count;
  logic [LEN_WIDTH-1:0]  r_len;

  logic                  w_in_ready;
  logic                  w_beat;
  logic                  w_last_beat;

  // A beat offered while abort (or reset) is asserted must not be consumed.
  assign w_in_ready  = r_in_ready & ~abort & ~reset;
  assign w_beat      = in_valid & w_in_ready;
  assign w_last_beat = (r_count == (r_len - 1'b1));

  always_ff @(posedge clock) begin
    r_done      <= 1'b0;
    r_acc_clear <= 1'b0;
    if (reset) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_err_start <= 1'b0;
      r_in_ready  <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_count     <= '0;
      r_len       <= '0;
    end else if (abort) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      if (start && (r_state != IDLE)) begin
        r_err_start <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_len       <= cfg_len;
            r_err_start <= 1'b0;
            r_busy      <= 1'b1;
            if (cfg_len != '0) begin
              r_state     <= CLEAR;
              r_acc_clear <= 1'b1;
            end else begin
              // Zero-length element: report an empty sum without touching the accumulator.
              r_state     <= RESULT;
              r_res_data  <= '0;
              r_res_valid <= 1'b1;
            end
          end
        end
        CLEAR: begin
          r_state    <= ACCUM;
          r_count    <= '0;
          r_in_ready <= 1'b1;
        end
        ACCUM: begin
          if (w_beat) begin
            if (w_last_beat) begin
              // acc_out already includes this beat, so it is the final sum.
              r_res_data  <= acc_out;
              r_res_valid <= 1'b1;
              r_in_ready  <= 1'b0;
              r_state     <= RESULT;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        RESULT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign err_start  = r_err_start;
  assign in_ready   = w_in_ready;
  assign acc_clear  = r_acc_clear;
  assign acc_enable = w_beat;
  assign acc_result = in_data;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;

endmodule
`default_nettype wire

// File: tb/tb_matrix_accumulate_controller.sv
`default_nettype none
// ==== tb_matrix_accumulate_controller : table, directed and random checks against a transaction model (rev 1.0) ====
module tb_matrix_accumulate_controller;

  localparam int DW = 64;
  localparam int LW = 8;

  logic          clock = 1'b0;
  logic          reset, start, abort, in_valid, res_ready;
  logic [LW-1:0] cfg_len;
  logic [DW-1:0] in_data;
  logic          busy, done, err_start, in_ready, acc_clear, acc_enable, res_valid;
  logic [DW-1:0] acc_result, acc_out, res_data;
  logic [DW-1:0] acc_q;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  matrix_accumulate_controller #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clock(clock), .reset(reset), .start(start), .cfg_len(cfg_len), .abort(abort),
    .busy(busy), .done(done), .err_start(err_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .acc_clear(acc_clear), .acc_enable(acc_enable), .acc_result(acc_result), .acc_out(acc_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  // Behavioural accumulator that the controller drives.
  assign acc_out = acc_q + (acc_enable ? acc_result : '0);
  always @(posedge clock) begin
    if (reset || acc_clear) acc_q <= '0;
    else if (acc_enable)    acc_q <= acc_out;
  end

  // Transaction-level reference: which phase the element is in, beats still owed, running sum.
  localparam int M_IDLE = 0, M_CLEAR = 1, M_COLLECT = 2, M_HOLD = 3;
  int          m_mode;
  int          m_left;
  int          m_len;
  logic [DW-1:0] m_sum, m_res;
  logic        m_err, m_done;

  typedef struct {
    logic          st;
    logic [LW-1:0] ln;
    logic          v;
    logic [DW-1:0] d;
    logic          rr;
    logic          ab;
    logic          e_busy, e_rdy, e_clr, e_en, e_rv, e_done;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, input logic [LW-1:0] ln, input logic v,
                       input logic [DW-1:0] d, input logic rr, input logic ab, input logic rs);
    start = st; cfg_len = ln; in_valid = v; in_data = d;
    res_ready = rr; abort = ab; reset = rs;
    #3;
  endtask

  task automatic model_check();
    logic exp_rdy;
    exp_rdy = (m_mode == M_COLLECT) && !abort && !reset;
    chk("busy",       busy,       (m_mode != M_IDLE));
    chk("in_ready",   in_ready,   exp_rdy);
    chk("acc_clear",  acc_clear,  (m_mode == M_CLEAR));
    chk("acc_enable", acc_enable, exp_rdy && in_valid);
    chk("res_valid",  res_valid,  (m_mode == M_HOLD));
    chk("done",       done,       m_done);
    chk("err_start",  err_start,  m_err);
    chk("res_data",   res_data,   m_res);
    if (acc_enable) chk("acc_result", acc_result, in_data);
  endtask

  task automatic model_step();
    m_done = 1'b0;
    if (reset) begin
      m_mode = M_IDLE; m_err = 1'b0; m_res = '0; m_len = 0; m_left = 0; m_sum = '0;
    end else if (abort) begin
      m_mode = M_IDLE;
    end else begin
      if (start && m_mode != M_IDLE) m_err = 1'b1;
      case (m_mode)
        M_IDLE: if (start) begin
          m_err = 1'b0;
          m_len = int'(cfg_len);
          if (m_len == 0) begin m_res = '0; m_mode = M_HOLD; end
          else m_mode = M_CLEAR;
        end
        M_CLEAR: begin m_mode = M_COLLECT; m_left = m_len; m_sum = '0; end
        M_COLLECT: if (in_valid) begin
          m_sum  = m_sum + in_data;
          m_left = m_left - 1;
          if (m_left == 0) begin m_res = m_sum; m_mode = M_HOLD; end
        end
        default: if (res_ready) begin m_done = 1'b1; m_mode = M_IDLE; end
      endcase
    end
    @(posedge clock);
    #1;
  endtask

  task automatic cyc(input logic st, input logic [LW-1:0] ln, input logic v,
                     input logic [DW-1:0] d, input logic rr, input logic ab, input logic rs);
    drive(st, ln, v, d, rr, ab, rs);
    model_check();
    model_step();
  endtask

  initial begin
    m_mode = M_IDLE; m_err = 1'b0; m_done = 1'b0; m_res = '0; m_sum = '0; m_left = 0; m_len = 0;

    // Power-up reset: outputs are undefined until the first reset edge.
    drive(0, 0, 0, '0, 0, 0, 1); model_step();
    drive(0, 0, 0, '0, 0, 0, 1); model_step();
    cyc(0, 0, 0, '0, 0, 0, 1);
    cyc(0, 0, 0, '0, 0, 0, 0);

    // Nominal len=4 element, one record per cycle starting with the start pulse.
    tbl[0] = '{1'b1, 8'd4, 1'b0, 64'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'd0, 1'b1, 64'd99, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'd0, 1'b1, 64'd1,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'd0, 1'b1, 64'd2,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'd0, 1'b1, 64'd3,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 8'd0, 1'b1, 64'd4,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 8'd0, 1'b0, 64'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 8'd0, 1'b0, 64'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 8'd0, 1'b0, 64'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].st, tbl[i].ln, tbl[i].v, tbl[i].d, tbl[i].rr, tbl[i].ab, 1'b0);
      chk($sformatf("tbl%0d_busy", i), busy,       tbl[i].e_busy);
      chk($sformatf("tbl%0d_rdy", i),  in_ready,   tbl[i].e_rdy);
      chk($sformatf("tbl%0d_clr", i),  acc_clear,  tbl[i].e_clr);
      chk($sformatf("tbl%0d_en", i),   acc_enable, tbl[i].e_en);
      chk($sformatf("tbl%0d_rv", i),   res_valid,  tbl[i].e_rv);
      chk($sformatf("tbl%0d_done", i), done,       tbl[i].e_done);
      if (tbl[i].e_rv) chk("tbl_res_data", res_data, 64'd10);
      model_check();
      model_step();
    end

    // Zero length: result of 0 one cycle after start, accumulator untouched.
    cyc(1, 0, 1, 64'd7, 0, 0, 0);
    drive(0, 0, 1, 64'd7, 0, 0, 0);
    chk("len0_rv", res_valid, 1'b1);
    chk("len0_clr", acc_clear, 1'b0);
    chk("len0_en", acc_enable, 1'b0);
    chk("len0_data", res_data, 64'd0);
    model_check(); model_step();
    cyc(0, 0, 0, '0, 1, 0, 0);
    cyc(0, 0, 0, '0, 0, 0, 0);

    // len=3 with gaps in valid and a stalled consumer.
    cyc(1, 3, 0, '0, 0, 0, 0);
    cyc(0, 0, 0, '0, 0, 0, 0);
    cyc(0, 0, 1, 64'h10, 0, 0, 0);
    cyc(0, 0, 0, 64'h55, 0, 0, 0);
    cyc(0, 0, 1, 64'h20, 0, 0, 0);
    cyc(0, 0, 0, 64'h66, 0, 0, 0);
    cyc(0, 0, 1, 64'h30, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 64'hdead, 0, 0, 0);
      chk("bp_rv_hold", res_valid, 1'b1);
      chk("bp_data_hold", res_data, 64'h60);
      model_check(); model_step();
    end
    cyc(0, 0, 0, '0, 1, 0, 0);
    drive(0, 0, 0, '0, 0, 0, 0);
    chk("bp_done", done, 1'b1);
    model_check(); model_step();

    // start while busy sets the sticky error; the element still completes.
    cyc(1, 3, 0, '0, 1, 0, 0);
    cyc(0, 0, 0, '0, 1, 0, 0);
    cyc(0, 0, 1, 64'd5, 1, 0, 0);
    cyc(1, 7, 1, 64'd6, 1, 0, 0);
    drive(0, 0, 1, 64'd7, 1, 0, 0);
    chk("err_set", err_start, 1'b1);
    model_check(); model_step();
    cyc(0, 0, 0, '0, 1, 0, 0);
    cyc(0, 0, 0, '0, 1, 0, 0);
    cyc(1, 1, 0, '0, 1, 0, 0);
    drive(0, 0, 0, '0, 1, 0, 0);
    chk("err_clear", err_start, 1'b0);
    model_check(); model_step();
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 64'd9, 1, 0, 0);

    // Abort on the second beat of len=5, then a clean len=2 element.
    cyc(1, 5, 0, '0, 1, 0, 0);
    cyc(0, 0, 0, '0, 1, 0, 0);
    cyc(0, 0, 1, 64'd100, 1, 0, 0);
    drive(0, 0, 1, 64'd200, 1, 1, 0);
    chk("abort_rdy", in_ready, 1'b0);
    chk("abort_en", acc_enable, 1'b0);
    model_check(); model_step();
    drive(0, 0, 1, 64'd200, 1, 0, 0);
    chk("abort_idle", busy, 1'b0);
    chk("abort_nodone", done, 1'b0);
    model_check(); model_step();
    cyc(1, 2, 0, '0, 1, 1, 0);
    cyc(1, 2, 0, '0, 1, 0, 0);
    cyc(0, 0, 0, '0, 1, 0, 0);
    cyc(0, 0, 1, 64'd11, 1, 0, 0);
    cyc(0, 0, 1, 64'd22, 1, 0, 0);
    drive(0, 0, 0, '0, 1, 0, 0);
    chk("post_abort_data", res_data, 64'd33);
    model_check(); model_step();
    cyc(0, 0, 0, '0, 1, 0, 0);

    // Reset held three cycles in the middle of accumulation.
    cyc(1, 6, 0, '0, 1, 0, 0);
    cyc(0, 0, 0, '0, 1, 0, 0);
    cyc(0, 0, 1, 64'd3, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 64'd4, 1, 0, 1);
    drive(0, 0, 1, 64'd4, 1, 0, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdy", in_ready, 1'b0);
    chk("rst_data", res_data, 64'd0);
    model_check(); model_step();

    // Random traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 5) == 0, LW'($urandom_range(0, 6)), $urandom_range(0, 9) < 7,
          {$urandom, $urandom}, $urandom_range(0, 9) < 6, $urandom_range(0, 59) == 0,
          $urandom_range(0, 399) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
